// File: rtl/loop_nest_ctrl.sv
// Loop-nest iteration controller: walks a nest of up to NUM_LOOPS counters
// (loop 0 innermost) and presents one iteration tuple per handshake.
module loop_nest_ctrl #(
    parameter int NUM_LOOPS   = 8,
    parameter int LOOP_ITER_W = 16,
    parameter int LOOP_ID_W   = 5
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             cfg_loop_iter_v,
    input  logic [LOOP_ITER_W-1:0]           cfg_loop_iter,
    input  logic [LOOP_ID_W-1:0]             cfg_loop_iter_loop_id,
    input  logic                             start,
    input  logic                             abort,
    output logic                             busy,
    output logic                             done,
    output logic                             step_valid,
    input  logic                             step_ready,
    output logic [NUM_LOOPS*LOOP_ITER_W-1:0] step_iter,
    output logic [NUM_LOOPS-1:0]             step_first,
    output logic [NUM_LOOPS-1:0]             step_carry
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [LOOP_ITER_W-1:0] cnt_q [NUM_LOOPS];
    logic [LOOP_ITER_W-1:0] cnt_d [NUM_LOOPS];
    logic [LOOP_ITER_W-1:0] max_q [NUM_LOOPS];
    logic [LOOP_ITER_W-1:0] max_d [NUM_LOOPS];
    logic [LOOP_ID_W-1:0]   top_q, top_d;

    logic [NUM_LOOPS-1:0]   active_s;
    logic [NUM_LOOPS-1:0]   at_max_s;
    logic [NUM_LOOPS-1:0]   at_zero_s;
    logic [NUM_LOOPS-1:0]   carry_s;
    logic [NUM_LOOPS-1:0]   first_s;
    logic [NUM_LOOPS-1:0]   top_sel_s;
    logic                   final_s;
    logic                   handshake_s;
    logic                   id_legal_s;
    logic                   cfg_we_s;

    // Per-loop status: loops above top_loop are masked so they never carry
    always_comb begin
        for (int i = 0; i < NUM_LOOPS; i++) begin
            active_s[i]  = (LOOP_ID_W'(i) <= top_q);
            top_sel_s[i] = (LOOP_ID_W'(i) == top_q);
            at_max_s[i]  = active_s[i] && (cnt_q[i] == max_q[i]);
            at_zero_s[i] = active_s[i] && (cnt_q[i] == '0);
        end
        carry_s[0] = at_max_s[0];
        first_s[0] = at_zero_s[0];
        for (int i = 1; i < NUM_LOOPS; i++) begin
            carry_s[i] = carry_s[i-1] & at_max_s[i];
            first_s[i] = first_s[i-1] & at_zero_s[i];
        end
    end

    assign final_s     = |(carry_s & top_sel_s);
    assign handshake_s = (state_q == ST_RUN) && step_ready;
    assign id_legal_s  = ({1'b0, cfg_loop_iter_loop_id} < (LOOP_ID_W+1)'(NUM_LOOPS));
    assign cfg_we_s    = cfg_loop_iter_v && (state_q == ST_IDLE) && id_legal_s;

    // Next-state logic: FSM, counter stepping and configuration writes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        top_d   = top_q;

        if (cfg_we_s) begin
            top_d = cfg_loop_iter_loop_id;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                if (cfg_loop_iter_loop_id == LOOP_ID_W'(i)) begin
                    max_d[i] = cfg_loop_iter;
                end else begin
                    max_d[i] = max_q[i];
                end
            end
        end else begin
            top_d = top_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    for (int i = 0; i < NUM_LOOPS; i++) cnt_d[i] = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // abort wins over a same-cycle handshake and never reports done
                    state_d = ST_IDLE;
                    for (int i = 0; i < NUM_LOOPS; i++) cnt_d[i] = '0;
                end else if (handshake_s && final_s) begin
                    state_d = ST_DONE;
                    for (int i = 0; i < NUM_LOOPS; i++) cnt_d[i] = '0;
                end else if (handshake_s) begin
                    state_d  = ST_RUN;
                    cnt_d[0] = carry_s[0] ? '0 : cnt_q[0] + LOOP_ITER_W'(1);
                    for (int i = 1; i < NUM_LOOPS; i++) begin
                        if (carry_s[i]) begin
                            cnt_d[i] = '0;
                        end else if (carry_s[i-1]) begin
                            cnt_d[i] = cnt_q[i] + LOOP_ITER_W'(1);
                        end else begin
                            cnt_d[i] = cnt_q[i];
                        end
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                for (int i = 0; i < NUM_LOOPS; i++) cnt_d[i] = '0;
            end
        endcase
    end

    // State, counter and configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            top_q   <= '0;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                cnt_q[i] <= '0;
                max_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            top_q   <= top_d;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                cnt_q[i] <= cnt_d[i];
                max_q[i] <= max_d[i];
            end
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign step_valid = (state_q == ST_RUN);
    assign step_first = first_s & {NUM_LOOPS{step_valid}};
    assign step_carry = carry_s & {NUM_LOOPS{step_valid}};

    // Pack the counters into the flat tuple bus
    always_comb begin
        step_iter = '0;
        for (int i = 0; i < NUM_LOOPS; i++) begin
            step_iter[i*LOOP_ITER_W +: LOOP_ITER_W] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_loop_nest_ctrl.sv
// Directed self-checking bench for loop_nest_ctrl.
module tb_loop_nest_ctrl;

    localparam int NL  = 8;
    localparam int W   = 16;
    localparam int IDW = 5;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            cfg_v;
    logic [W-1:0]    cfg_val;
    logic [IDW-1:0]  cfg_id;
    logic            start;
    logic            abort;
    logic            busy;
    logic            done;
    logic            step_valid;
    logic            step_ready;
    logic [NL*W-1:0] step_iter;
    logic [NL-1:0]   step_first;
    logic [NL-1:0]   step_carry;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    loop_nest_ctrl #(.NUM_LOOPS(NL), .LOOP_ITER_W(W), .LOOP_ID_W(IDW)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .cfg_loop_iter_v       (cfg_v),
        .cfg_loop_iter         (cfg_val),
        .cfg_loop_iter_loop_id (cfg_id),
        .start                 (start),
        .abort                 (abort),
        .busy                  (busy),
        .done                  (done),
        .step_valid            (step_valid),
        .step_ready            (step_ready),
        .step_iter             (step_iter),
        .step_first            (step_first),
        .step_carry            (step_carry)
    );

    typedef struct {
        logic       start;
        logic       ready;
        logic       abort;
        logic       valid;
        logic       busy;
        logic       done;
        int         i0;
        int         i1;
        logic [7:0] first;
        logic [7:0] carry;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic rd, input logic ab, input logic v,
                       input logic b, input logic d, input int i0, input int i1,
                       input logic [7:0] f, input logic [7:0] c);
        vec_t e;
        e.start = st; e.ready = rd; e.abort = ab; e.valid = v; e.busy = b; e.done = d;
        e.i0 = i0; e.i1 = i1; e.first = f; e.carry = c;
        tbl.push_back(e);
    endtask

    task automatic cfg(input logic [IDW-1:0] id, input logic [W-1:0] val);
        @(negedge clk);
        cfg_v = 1'b1; cfg_id = id; cfg_val = val;
        @(negedge clk);
        cfg_v = 1'b0;
    endtask

    // Start a nest with ready held high; count valid cycles until done.
    task automatic run_to_done(input int limit, output int steps, output logic [W-1:0] last_i0,
                               output logic [NL-1:0] last_first, output logic [NL-1:0] last_carry);
        int cyc;
        logic seen_done;
        steps = 0; last_i0 = '0; last_first = '0; last_carry = '0; seen_done = 1'b0;
        @(negedge clk);
        start = 1'b1; step_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < limit; cyc++) begin
            if (step_valid) begin
                steps++;
                last_i0 = step_iter[W-1:0];
                last_first = step_first;
                last_carry = step_carry;
            end
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("run_done_reached", {63'd0, seen_done}, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int steps;
        logic [W-1:0]  li0;
        logic [NL-1:0] lf, lc;

        reset_n = 1'b0; cfg_v = 1'b0; cfg_val = '0; cfg_id = '0;
        start = 1'b0; abort = 1'b0; step_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_valid", {63'd0, step_valid}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        reset_n = 1'b1;

        // Single loop, max0=3
        cfg(5'd0, 16'd3);
        @(negedge clk);
        start = 1'b1; step_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("s1_valid", {63'd0, step_valid}, 64'd1);
            chk("s1_iter0", {48'd0, step_iter[15:0]}, 64'(k));
            chk("s1_carry0", {63'd0, step_carry[0]}, (k == 3) ? 64'd1 : 64'd0);
            @(negedge clk);
        end
        chk("s1_done", {63'd0, done}, 64'd1);
        chk("s1_valid_off", {63'd0, step_valid}, 64'd0);
        @(negedge clk);
        chk("s1_idle_busy", {63'd0, busy}, 64'd0);
        chk("s1_idle_done", {63'd0, done}, 64'd0);

        // Two-loop nest: max0=1, max1=2, top=1
        cfg(5'd0, 16'd1);
        cfg(5'd1, 16'd2);
        // continuous ready
        add(1,1,0, 0,0,0, 0,0, 8'h00, 8'h00);
        add(0,1,0, 1,1,0, 0,0, 8'h03, 8'h00);
        add(0,1,0, 1,1,0, 1,0, 8'h00, 8'h01);
        add(0,1,0, 1,1,0, 0,1, 8'h01, 8'h00);
        add(0,1,0, 1,1,0, 1,1, 8'h00, 8'h01);
        add(0,1,0, 1,1,0, 0,2, 8'h01, 8'h00);
        add(0,1,0, 1,1,0, 1,2, 8'h00, 8'h03);
        add(1,1,1, 0,1,1, 0,0, 8'h00, 8'h00);   // start/abort in DONE ignored
        add(1,1,0, 0,0,0, 0,0, 8'h00, 8'h00);
        // alternating ready 1,0,1,0...
        add(0,1,0, 1,1,0, 0,0, 8'h03, 8'h00);
        add(0,0,0, 1,1,0, 1,0, 8'h00, 8'h01);
        add(0,1,0, 1,1,0, 1,0, 8'h00, 8'h01);
        add(1,0,0, 1,1,0, 0,1, 8'h01, 8'h00);   // start in RUN ignored
        add(0,1,0, 1,1,0, 0,1, 8'h01, 8'h00);
        add(0,0,0, 1,1,0, 1,1, 8'h00, 8'h01);
        add(0,1,0, 1,1,0, 1,1, 8'h00, 8'h01);
        add(0,0,0, 1,1,0, 0,2, 8'h01, 8'h00);
        add(0,1,0, 1,1,0, 0,2, 8'h01, 8'h00);
        add(0,0,0, 1,1,0, 1,2, 8'h00, 8'h03);
        add(0,1,0, 1,1,0, 1,2, 8'h00, 8'h03);
        add(0,0,0, 0,1,1, 0,0, 8'h00, 8'h00);
        add(0,0,0, 0,0,0, 0,0, 8'h00, 8'h00);

        foreach (tbl[n]) begin
            @(negedge clk);
            chk($sformatf("v%0d_valid", n), {63'd0, step_valid}, {63'd0, tbl[n].valid});
            chk($sformatf("v%0d_busy", n), {63'd0, busy}, {63'd0, tbl[n].busy});
            chk($sformatf("v%0d_done", n), {63'd0, done}, {63'd0, tbl[n].done});
            chk($sformatf("v%0d_i0", n), {48'd0, step_iter[15:0]}, 64'(tbl[n].i0));
            chk($sformatf("v%0d_i1", n), {48'd0, step_iter[31:16]}, 64'(tbl[n].i1));
            chk($sformatf("v%0d_first", n), {56'd0, step_first}, {56'd0, tbl[n].first});
            chk($sformatf("v%0d_carry", n), {56'd0, step_carry}, {56'd0, tbl[n].carry});
            start = tbl[n].start; step_ready = tbl[n].ready; abort = tbl[n].abort;
        end
        start = 1'b0; abort = 1'b0;

        // Abort after two handshakes (same config)
        @(negedge clk);
        start = 1'b1; step_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ab_tuple_i0", {48'd0, step_iter[15:0]}, 64'd0);
        chk("ab_tuple_i1", {48'd0, step_iter[31:16]}, 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_valid", {63'd0, step_valid}, 64'd0);
        chk("ab_busy", {63'd0, busy}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk("ab_no_done", {63'd0, done}, 64'd0);
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ab_restart_valid", {63'd0, step_valid}, 64'd1);
        chk("ab_restart_iter", {32'd0, step_iter[31:0]}, 64'd0);
        begin
            int guard = 0;
            while (!done && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            chk("ab_restart_done", {63'd0, done}, 64'd1);
        end
        @(negedge clk);

        // All loops, every max=0: one step, all first/carry set
        for (int i = 0; i < NL; i++) cfg(IDW'(i), 16'd0);
        run_to_done(20, steps, li0, lf, lc);
        chk("all0_steps", 64'(steps), 64'd1);
        chk("all0_first", {56'd0, lf}, 64'hFF);
        chk("all0_carry", {56'd0, lc}, 64'hFF);

        // Reset in the middle of a nest
        cfg(5'd0, 16'd3);
        @(negedge clk);
        start = 1'b1; step_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rm_pre_iter0", {48'd0, step_iter[15:0]}, 64'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("rm_busy", {63'd0, busy}, 64'd0);
        chk("rm_valid", {63'd0, step_valid}, 64'd0);
        chk("rm_done", {63'd0, done}, 64'd0);
        chk("rm_iter", step_iter[63:0], 64'd0);
        chk("rm_carry", {56'd0, step_carry}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rm_no_done", {62'd0, done, busy}, 64'd0);
        end
        cfg(5'd0, 16'd3);
        cfg(5'd9, 16'd0);               // out-of-range id dropped
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rc_iter0", {48'd0, step_iter[15:0]}, 64'(k));
            chk("rc_carry", {56'd0, step_carry}, (k == 3) ? 64'd1 : 64'd0);
            cfg_v = (k < 2); cfg_id = IDW'(k); cfg_val = (k == 0) ? 16'd0 : 16'd5;
            @(negedge clk);
        end
        cfg_v = 1'b0;
        chk("rc_done", {63'd0, done}, 64'd1);
        @(negedge clk);

        // Max all-ones on loop 0: 65536 steps, no overflow
        cfg(5'd0, 16'hFFFF);
        run_to_done(70000, steps, li0, lf, lc);
        chk("ff_steps", 64'(steps), 64'd65536);
        chk("ff_last_i0", {48'd0, li0}, 64'hFFFF);
        chk("ff_last_carry", {56'd0, lc}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
